// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-2 alternating demultiplexer.
package demux_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
  localparam int NUM_LANES = 2;
  localparam int LANE0     = 0;
  localparam int LANE1     = 1;
  localparam int CNT_W     = 8;

  typedef logic [0:0] lane_t;

  // Round-robin between the two lanes.
  function automatic lane_t next_lane(lane_t l);
    return ~l;
  endfunction

endpackage

// File: rtl/demux_lane_fifo.sv
// Per-lane FIFO: registered storage, combinational head read.
// Pointers wrap modulo DEPTH (power of two); a pop on an empty FIFO and
// a push on a full FIFO are both ignored.
module demux_lane_fifo
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      occ;
  logic             do_push, do_pop;

  assign full    = (occ == (AW+1)'(DEPTH));
  assign empty   = (occ == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Head is forced to zero while empty so reset shows a clean output.
  assign rdata = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; push+pop together holds occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Storage array, no reset needed: contents are masked by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/demux_1a2.sv
// 1-to-2 demultiplexer: accepted words alternate lane 0, lane 1, ...
// Each lane buffers in its own FIFO. Input stalls while the selected lane
// is full; the selector never skips a full lane.
// Optional feature: define DEMUX_STAT_EN to add per-lane 8-bit
// accepted-word counters (count_0_c / count_1_c, wrapping).
module demux_1a2
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in_c,
  input  logic             valid_in_c,
  output logic             ready_in_c,
  output logic [WIDTH-1:0] data_out_0_c,
  output logic             valid_out_0_c,
  input  logic             pop_0_c,
  output logic [WIDTH-1:0] data_out_1_c,
  output logic             valid_out_1_c,
  input  logic             pop_1_c
`ifdef DEMUX_STAT_EN
  ,
  output logic [CNT_W-1:0] count_0_c,
  output logic [CNT_W-1:0] count_1_c
`endif
);

  lane_t                              sel;
  logic                               accept;
  logic [NUM_LANES-1:0]               push, pop, full, empty;
  logic [NUM_LANES-1:0][WIDTH-1:0]    rdata;

  // Ready depends only on registered occupancy, never on same-cycle pops.
  assign ready_in_c = ~full[sel];
  assign accept     = valid_in_c & ready_in_c;
  assign pop        = {pop_1_c, pop_0_c};

  // Steer the accepted word to the currently selected lane.
  always_comb begin
    push      = '0;
    push[sel] = accept;
  end

  // Selector toggles on every accept, starts at lane 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      sel <= lane_t'(LANE0);
    else if (accept) sel <= next_lane(sel);
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    demux_lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push[i]),
      .pop   (pop[i]),
      .wdata (data_in_c),
      .rdata (rdata[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end

  assign data_out_0_c  = rdata[LANE0];
  assign data_out_1_c  = rdata[LANE1];
  assign valid_out_0_c = ~empty[LANE0];
  assign valid_out_1_c = ~empty[LANE1];

`ifdef DEMUX_STAT_EN
  logic [NUM_LANES-1:0][CNT_W-1:0] cnt;

  // Per-lane accept counters, wrap naturally at 0xFF.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++)
        if (push[i]) cnt[i] <= cnt[i] + 1'b1;
    end
  end

  assign count_0_c = cnt[LANE0];
  assign count_1_c = cnt[LANE1];
`endif

endmodule

// File: tb/tb_demux_1a2.sv
// Bench for demux_1a2: directed scenarios plus randomized traffic checked
// against a queue-based reference model.
module tb_demux_1a2;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] data_in_c = '0;
  logic             valid_in_c = 1'b0;
  logic             ready_in_c;
  logic [WIDTH-1:0] data_out_0_c, data_out_1_c;
  logic             valid_out_0_c, valid_out_1_c;
  logic             pop_0_c = 1'b0, pop_1_c = 1'b0;
`ifdef DEMUX_STAT_EN
  logic [7:0]       count_0_c, count_1_c;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Reference model
  logic [7:0] q0[$], q1[$];
  bit         msel;
  int         mcnt0, mcnt1;

  demux_1a2 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .data_in_c     (data_in_c),
    .valid_in_c    (valid_in_c),
    .ready_in_c    (ready_in_c),
    .data_out_0_c  (data_out_0_c),
    .valid_out_0_c (valid_out_0_c),
    .pop_0_c       (pop_0_c),
    .data_out_1_c  (data_out_1_c),
    .valid_out_1_c (valid_out_1_c),
    .pop_1_c       (pop_1_c)
`ifdef DEMUX_STAT_EN
    ,
    .count_0_c     (count_0_c),
    .count_1_c     (count_1_c)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  function automatic bit m_ready();
    return (msel ? q1.size() : q0.size()) < DEPTH;
  endfunction

  task automatic m_reset();
    q0.delete(); q1.delete();
    msel = 1'b0; mcnt0 = 0; mcnt1 = 0;
  endtask

  // Advance one clock and apply the same edge to the model; returns at negedge.
  task automatic tick();
    bit acc, e0, e1;
    logic [7:0] d;
    acc = valid_in_c && m_ready();
    e0  = pop_0_c && q0.size() > 0;
    e1  = pop_1_c && q1.size() > 0;
    d   = data_in_c;
    @(posedge clk);
    if (e0) void'(q0.pop_front());
    if (e1) void'(q1.pop_front());
    if (acc) begin
      if (!msel) begin q0.push_back(d); mcnt0 = (mcnt0 + 1) % 256; end
      else       begin q1.push_back(d); mcnt1 = (mcnt1 + 1) % 256; end
      msel = !msel;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    valid_in_c = 1'b0; pop_0_c = 1'b0; pop_1_c = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; idle(); valid_in_c = 1'b1; data_in_c = 8'h77;
    repeat (2) @(negedge clk);
    m_reset();
    vectors++; if (ready_in_c !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b want 1", ready_in_c); end
    vectors++; if (valid_out_0_c !== 1'b0) begin miscompares++; $display("FAIL rst_v0: got %b want 0", valid_out_0_c); end
    vectors++; if (valid_out_1_c !== 1'b0) begin miscompares++; $display("FAIL rst_v1: got %b want 0", valid_out_1_c); end
    vectors++; if (data_out_0_c !== 8'h00) begin miscompares++; $display("FAIL rst_d0: got %h want 00", data_out_0_c); end
    vectors++; if (data_out_1_c !== 8'h00) begin miscompares++; $display("FAIL rst_d1: got %h want 00", data_out_1_c); end
    idle();
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_alternate();
    logic [7:0] pat [4];
    pat = '{8'h11, 8'hFF, 8'h12, 8'hFE};
    for (int i = 0; i < 4; i++) begin
      valid_in_c = 1'b1; data_in_c = pat[i];
      tick();
      if (i == 0) begin
        vectors++; if (valid_out_0_c !== 1'b1) begin miscompares++; $display("FAIL alt_latency_v0: got %b want 1", valid_out_0_c); end
        vectors++; if (data_out_0_c !== 8'h11) begin miscompares++; $display("FAIL alt_latency_d0: got %h want 11", data_out_0_c); end
      end
    end
    idle();
    vectors++; if (data_out_0_c !== 8'h11) begin miscompares++; $display("FAIL alt_head0: got %h want 11", data_out_0_c); end
    vectors++; if (data_out_1_c !== 8'hFF) begin miscompares++; $display("FAIL alt_head1: got %h want ff", data_out_1_c); end
    pop_0_c = 1'b1; tick(); pop_0_c = 1'b0;
    vectors++; if (data_out_0_c !== 8'h12) begin miscompares++; $display("FAIL alt_next0: got %h want 12", data_out_0_c); end
    pop_1_c = 1'b1; tick(); pop_1_c = 1'b0;
    vectors++; if (data_out_1_c !== 8'hFE) begin miscompares++; $display("FAIL alt_next1: got %h want fe", data_out_1_c); end
    pop_0_c = 1'b1; pop_1_c = 1'b1; tick(); idle();
    vectors++; if ({valid_out_0_c, valid_out_1_c} !== 2'b00) begin miscompares++; $display("FAIL alt_drained: got %b want 00", {valid_out_0_c, valid_out_1_c}); end
  endtask

  task automatic test_full_stall();
    for (int i = 1; i <= 8; i++) begin
      valid_in_c = 1'b1; data_in_c = 8'(i);
      vectors++; if (ready_in_c !== 1'b1) begin miscompares++; $display("FAIL full_fill_ready[%0d]: got %b want 1", i, ready_in_c); end
      tick();
    end
    data_in_c = 8'h09;
    vectors++; if (ready_in_c !== 1'b0) begin miscompares++; $display("FAIL full_stall_ready: got %b want 0", ready_in_c); end
    tick();
    vectors++; if (ready_in_c !== 1'b0) begin miscompares++; $display("FAIL full_stall_hold: got %b want 0", ready_in_c); end
    pop_0_c = 1'b1;
    vectors++; if (ready_in_c !== 1'b0) begin miscompares++; $display("FAIL full_pop_no_bypass: got %b want 0", ready_in_c); end
    tick(); pop_0_c = 1'b0;
    vectors++; if (ready_in_c !== 1'b1) begin miscompares++; $display("FAIL full_ready_after_pop: got %b want 1", ready_in_c); end
    tick(); idle();
    for (int k = 0; k < 4; k++) begin
      vectors++; if (data_out_0_c !== 8'(3 + 2*k)) begin miscompares++; $display("FAIL full_drain0[%0d]: got %h want %h", k, data_out_0_c, 8'(3 + 2*k)); end
      vectors++; if (data_out_1_c !== 8'(2 + 2*k)) begin miscompares++; $display("FAIL full_drain1[%0d]: got %h want %h", k, data_out_1_c, 8'(2 + 2*k)); end
      pop_0_c = 1'b1; pop_1_c = 1'b1; tick(); idle();
    end
    vectors++; if ({valid_out_0_c, valid_out_1_c} !== 2'b00) begin miscompares++; $display("FAIL full_empty: got %b want 00", {valid_out_0_c, valid_out_1_c}); end
  endtask

  task automatic test_empty_pop();
    // selector is on lane 1 after an odd number of accepts
    pop_1_c = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (valid_out_1_c !== 1'b0) begin miscompares++; $display("FAIL epop_v1[%0d]: got %b want 0", i, valid_out_1_c); end
    end
    pop_1_c = 1'b0;
    valid_in_c = 1'b1; data_in_c = 8'h5A; tick(); idle();
    vectors++; if (valid_out_1_c !== 1'b1) begin miscompares++; $display("FAIL epop_v1_after: got %b want 1", valid_out_1_c); end
    vectors++; if (data_out_1_c !== 8'h5A) begin miscompares++; $display("FAIL epop_d1: got %h want 5a", data_out_1_c); end
    vectors++; if (valid_out_0_c !== 1'b0) begin miscompares++; $display("FAIL epop_v0: got %b want 0", valid_out_0_c); end
    pop_1_c = 1'b1; tick(); idle();
    vectors++; if (valid_out_1_c !== 1'b0) begin miscompares++; $display("FAIL epop_v1_drain: got %b want 0", valid_out_1_c); end
  endtask

  task automatic test_push_pop();
    logic [7:0] w [4];
    w = '{8'h30, 8'h40, 8'h31, 8'h41};
    for (int i = 0; i < 4; i++) begin
      valid_in_c = 1'b1; data_in_c = w[i]; tick();
    end
    valid_in_c = 1'b1; data_in_c = 8'h20; pop_0_c = 1'b1; tick(); idle();
    vectors++; if (data_out_0_c !== 8'h31) begin miscompares++; $display("FAIL pp_head: got %h want 31", data_out_0_c); end
    pop_0_c = 1'b1; tick(); pop_0_c = 1'b0;
    vectors++; if ({valid_out_0_c, data_out_0_c} !== {1'b1, 8'h20}) begin miscompares++; $display("FAIL pp_second: got %b/%h want 1/20", valid_out_0_c, data_out_0_c); end
    pop_0_c = 1'b1; tick(); pop_0_c = 1'b0;
    vectors++; if (valid_out_0_c !== 1'b0) begin miscompares++; $display("FAIL pp_occ2: got %b want 0", valid_out_0_c); end
    vectors++; if (data_out_1_c !== 8'h40) begin miscompares++; $display("FAIL pp_lane1a: got %h want 40", data_out_1_c); end
    pop_1_c = 1'b1; tick(); pop_1_c = 1'b0;
    vectors++; if (data_out_1_c !== 8'h41) begin miscompares++; $display("FAIL pp_lane1b: got %h want 41", data_out_1_c); end
    pop_1_c = 1'b1; tick(); idle();
  endtask

  task automatic test_async_reset();
    // selector now points at lane 1
    for (int i = 0; i < 3; i++) begin
      valid_in_c = 1'b1; data_in_c = 8'(8'h50 + i); tick();
    end
    idle();
    vectors++; if ({valid_out_0_c, valid_out_1_c} !== 2'b11) begin miscompares++; $display("FAIL ar_loaded: got %b want 11", {valid_out_0_c, valid_out_1_c}); end
    #2 reset = 1'b0;
    #1;
    m_reset();
    vectors++; if ({valid_out_0_c, valid_out_1_c} !== 2'b00) begin miscompares++; $display("FAIL ar_valid_drop: got %b want 00", {valid_out_0_c, valid_out_1_c}); end
    vectors++; if (ready_in_c !== 1'b1) begin miscompares++; $display("FAIL ar_ready: got %b want 1", ready_in_c); end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    valid_in_c = 1'b1; data_in_c = 8'hAA; tick(); idle();
    vectors++; if ({valid_out_0_c, data_out_0_c} !== {1'b1, 8'hAA}) begin miscompares++; $display("FAIL ar_first_lane0: got %b/%h want 1/aa", valid_out_0_c, data_out_0_c); end
    vectors++; if (valid_out_1_c !== 1'b0) begin miscompares++; $display("FAIL ar_lane1_empty: got %b want 0", valid_out_1_c); end
    pop_0_c = 1'b1; tick(); idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      valid_in_c = ($urandom_range(0, 3) != 0);
      data_in_c  = 8'($urandom);
      pop_0_c    = ($urandom_range(0, 2) == 0);
      pop_1_c    = ($urandom_range(0, 2) == 0);
      vectors++; if (ready_in_c !== m_ready()) begin miscompares++; $display("FAIL rnd_ready[%0d]: got %b want %b", n, ready_in_c, m_ready()); end
      vectors++; if (valid_out_0_c !== (q0.size() != 0)) begin miscompares++; $display("FAIL rnd_v0[%0d]: got %b want %b", n, valid_out_0_c, q0.size() != 0); end
      vectors++; if (valid_out_1_c !== (q1.size() != 0)) begin miscompares++; $display("FAIL rnd_v1[%0d]: got %b want %b", n, valid_out_1_c, q1.size() != 0); end
      if (q0.size() != 0) begin
        vectors++; if (data_out_0_c !== q0[0]) begin miscompares++; $display("FAIL rnd_d0[%0d]: got %h want %h", n, data_out_0_c, q0[0]); end
      end
      if (q1.size() != 0) begin
        vectors++; if (data_out_1_c !== q1[0]) begin miscompares++; $display("FAIL rnd_d1[%0d]: got %h want %h", n, data_out_1_c, q1[0]); end
      end
`ifdef DEMUX_STAT_EN
      vectors++; if ({count_0_c, count_1_c} !== {8'(mcnt0), 8'(mcnt1)}) begin miscompares++; $display("FAIL rnd_cnt[%0d]: got %h/%h want %h/%h", n, count_0_c, count_1_c, 8'(mcnt0), 8'(mcnt1)); end
`endif
      tick();
    end
    idle();
  endtask

`ifdef DEMUX_STAT_EN
  task automatic test_stats();
    int acc;
    int guard;
    acc = 0; guard = 0;
    reset = 1'b0; @(negedge clk); m_reset(); reset = 1'b1; @(negedge clk);
    while (acc < 512 && guard < 2000) begin
      valid_in_c = 1'b1; data_in_c = 8'($urandom); pop_0_c = 1'b1; pop_1_c = 1'b1;
      vectors++; if ({count_0_c, count_1_c} !== {8'(mcnt0), 8'(mcnt1)}) begin miscompares++; $display("FAIL stat_track[%0d]: got %h/%h want %h/%h", acc, count_0_c, count_1_c, 8'(mcnt0), 8'(mcnt1)); end
      if (m_ready()) acc++;
      tick(); guard++;
    end
    idle();
    vectors++; if (acc != 512) begin miscompares++; $display("FAIL stat_budget: got %0d accepts want 512", acc); end
    vectors++; if ({count_0_c, count_1_c} !== 16'h0000) begin miscompares++; $display("FAIL stat_wrap: got %h/%h want 00/00", count_0_c, count_1_c); end
  endtask
`endif

  initial begin
    m_reset();
    test_reset();
    test_alternate();
    test_full_stall();
    test_empty_pop();
    test_push_pop();
    test_async_reset();
    test_random();
`ifdef DEMUX_STAT_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/demux_1a2.md
DEMUX_1A2 -- requirements
Module: demux_1a2

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits.
REQ-002 Parameter DEPTH, default 4: entries per output lane FIFO; power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-005 data_in_c  input  WIDTH  incoming word.
REQ-006 valid_in_c  input  1  data_in_c holds a word this cycle.
REQ-007 ready_in_c  output  1  block accepts a word this cycle.
REQ-008 data_out_0_c  output  WIDTH  head word of lane 0.
REQ-009 valid_out_0_c  output  1  lane 0 FIFO is non-empty.
REQ-010 pop_0_c  input  1  consumer removes the lane 0 head word this cycle.
REQ-011 data_out_1_c, valid_out_1_c, pop_1_c: same as REQ-008 to REQ-010, for lane 1.
REQ-012 count_0_c, count_1_c  output  8  per-lane accepted-word counters; present only when DEMUX_STAT_EN is defined.

Function
REQ-013 Accept = valid_in_c & ready_in_c sampled at a rising clk edge; only accepted words change state.
REQ-014 Internal lane selector sel SHALL be 0 after reset and toggle on every accept; no toggle without an accept.
REQ-015 An accepted word SHALL be written to the tail of the FIFO of lane sel, so words alternate lane 0, lane 1, lane 0, ...
REQ-016 ready_in_c = NOT full(lane sel), combinational from registered state; a same-cycle pop on the full lane does NOT raise ready_in_c.
REQ-017 Latency: a word accepted at edge N SHALL appear on data_out_x_c with valid_out_x_c=1 after edge N, if its lane was empty.
REQ-018 data_out_x_c SHALL show the FIFO head (registered storage, combinational read); its value is don't-care while valid_out_x_c=0.
REQ-019 pop_x_c with valid_out_x_c=1 SHALL advance that lane's head at the edge; pop_x_c on an empty lane SHALL be ignored, with no pointer change.
REQ-020 Simultaneous push and pop on the same non-full, non-empty lane SHALL keep its occupancy unchanged and preserve order.
REQ-021 Each lane's read and write pointers SHALL wrap modulo DEPTH; occupancy counter width is log2(DEPTH)+1; full = DEPTH entries.
REQ-022 Lanes are independent: a full lane 1 SHALL NOT stall pops on lane 0, and vice versa.
REQ-023 The selector SHALL NOT skip a full lane; input stalls until the selected lane has space.

Reset
REQ-024 While reset=0: sel=0, all pointers and occupancies 0, valid_out_0_c=valid_out_1_c=0, ready_in_c=1, counters 0, data_out_x_c=0.
REQ-025 Reset asserted mid-stream SHALL discard all buffered words without draining; the first accept after release goes to lane 0.

Configuration
REQ-026 Macro DEMUX_STAT_EN defined: count_0_c and count_1_c SHALL increment on each accept into their lane and wrap 0xFF->0x00.
REQ-027 Macro DEMUX_STAT_EN undefined: the count ports and counter logic are absent; all other behaviour is identical.

Structure
REQ-028 Shared package demux_pkg SHALL hold the WIDTH/DEPTH defaults and the lane index constants LANE0=0 and LANE1=1.
REQ-029 Each lane SHALL be one instance of sub-module demux_lane_fifo (push, pop, data, full, empty); the top level holds only the selector, ready logic and counters.

Verification
REQ-030 After reset, drive 0x11,0xFF,0x12,0xFE continuously with pops low -> lane 0 holds 0x11,0x12; lane 1 holds 0xFF,0xFE; valid_out_0_c=1 one edge after 0x11 is accepted.
REQ-031 DEPTH=4, no pops, drive 9 words 0x01..0x09 -> 8 accepted; ready_in_c=0 with 0x09 pending for lane 0; pop_0_c for one cycle -> 0x09 accepted on the next edge.
REQ-032 pop_1_c held high while lane 1 is empty -> no pointer change, valid_out_1_c stays 0, and the next lane-1 word reads out correctly.
REQ-033 Lane 0 holds 2 words; push 0x20 to lane 0 and pop lane 0 in the same cycle -> occupancy stays 2; output order is old head+1, then 0x20.
REQ-034 Assert reset=0 asynchronously between edges with 3 words buffered -> valid_outs drop at once, ready_in_c=1; next word 0xAA lands in lane 0.
REQ-035 With DEMUX_STAT_EN defined, accept 512 words -> count_0_c=count_1_c=0x00 (wrapped) and the counts track exactly throughout.
